wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the NPC core, sitting directly upstream of the register file. It accepts completed instructions from the execute stage over a valid/ready handshake and waits for load data from the LSU when required. Load data is sign/zero-extended by lane. The stage then drives the register file write port (`rf_wen`/`rf_waddr`/`rf_wdata`) for exactly one cycle per instruction, alongside a commit pulse used by the simulation environment.

## Interface
Parameters:
- `ADDR_WIDTH`, 5, register index width (32 architectural registers).
- `DATA_WIDTH`, 32, datapath width. The load-extension path is defined for 32 only.

Ports:
- `clk` in 1: core clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: execute stage presents an instruction.
- `in_ready` out 1: stage can accept this cycle.
- `in_pc` in DATA_WIDTH: PC of the instruction.
- `in_rd` in ADDR_WIDTH: destination register.
- `in_rd_wen` in 1: instruction writes `rd`.
- `in_result` in DATA_WIDTH: ALU/CSR/link result (non-load).
- `in_is_load` in 1: instruction is a load.
- `in_load_fn` in 3: funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- `in_addr_lo` in 2: load address bits [1:0].
- `mem_rvalid` in 1: LSU read data valid (single-cycle pulse).
- `mem_rdata` in DATA_WIDTH: LSU read word (aligned word).
- `rf_wen` out 1: register file write enable.
- `rf_waddr` out ADDR_WIDTH: register file write address.
- `rf_wdata` out DATA_WIDTH: register file write data.
- `commit_valid` out 1: one-cycle pulse per retired instruction.
- `commit_pc` out DATA_WIDTH: PC of the retiring instruction.
- `byp_valid` out 1: bypass entry valid (see Configuration).
- `byp_addr` out ADDR_WIDTH: bypass destination register.
- `byp_data` out DATA_WIDTH: bypass data.

## Operation
States:
- IDLE: nothing held.
- WAIT_MEM: a load is held and is waiting for `mem_rvalid`.
- WRITE: the held instruction retires this cycle.

Handshake and state transitions:
- `in_ready` = (state == IDLE) || (state == WRITE). An accept is `in_valid && in_ready`.
- On accept, the stage latches pc, rd, rd_wen, result, is_load, load_fn and addr_lo.
  - If the instruction is not a load, the next state is WRITE and the data register takes `in_result`.
  - If it is a load, the next state is WAIT_MEM.
- In WAIT_MEM, when `mem_rvalid` is high, the data register takes the extended load value and the next state is WRITE.
- In WRITE, with no accept, the next state is IDLE. With an accept, the transitions above apply, so back-to-back non-load instructions are accepted at 1 per cycle.

Outputs in WRITE:
- `rf_wen` = held rd_wen && held rd != 0. Writes to x0 are suppressed.
- `rf_waddr` = held rd.
- `rf_wdata` = data register.
- `commit_valid` = 1 and `commit_pc` = held pc.
- In every other state, `rf_wen` and `commit_valid` are 0.

Load extension:
- s = `mem_rdata` >> (8 × addr_lo), with zero fill.
- LB: sext(s[7:0]). LBU: zext(s[7:0]).
- LH: sext(s[15:0]). LHU: zext(s[15:0]).
- LW: `mem_rdata` unshifted.
- Codes 011, 110 and 111 are treated as LW.
- Misaligned halfwords (addr_lo = 3) use the zero-filled s. No trap is raised.

Ignored inputs:
- `mem_rvalid` outside WAIT_MEM is ignored.
- `in_*` values are ignored unless an accept occurs.

## Timing
- Reset values:
  - state = IDLE.
  - `in_ready` = 1.
  - `rf_wen`, `commit_valid`, `byp_valid` = 0.
  - `rf_waddr`, `rf_wdata`, `commit_pc`, `byp_addr`, `byp_data` = 0.
- Non-load latency: accept at edge N; `rf_wen`/`commit_valid` are high during cycle N..N+1 and the register file captures the value at edge N+1.
- Load latency: accept at edge N. If `mem_rvalid` is sampled at edge M > N, the write is high during cycle M..M+1.
- The earliest legal `mem_rvalid` is the cycle after the accept.
- All outputs are combinational from registered state only; there is no input-to-output combinational path.
- Asserting `rst` mid-load drops the held instruction: no write and no commit. The stage returns to IDLE immediately.

## Configuration
- Macro: `WB_BYPASS_EN`.
- With the macro defined:
  - `byp_valid` = (state == WRITE) && `rf_wen`.
  - `byp_addr` = `rf_waddr`.
  - `byp_data` = `rf_wdata`.
  - Decode uses these to forward the value being written this cycle, since the register file read is not write-through.
- Without the macro: `byp_valid`, `byp_addr` and `byp_data` are tied to 0, and the bypass logic is not present.

## Test plan
- ALU instruction: rd=5, result=0x1234, rd_wen=1, accepted at edge 1. Required: `rf_wen`=1, `rf_waddr`=5, `rf_wdata`=0x1234 and `commit_valid`=1 for exactly one cycle after edge 1.
- Back-to-back ALU instructions to x1, x2, x3 on consecutive cycles. Required: `in_ready` stays 1 and three consecutive write cycles occur in order.
- LB, addr_lo=2, `mem_rdata`=0x0080FF00, `mem_rvalid` 3 cycles after accept. Required: `in_ready`=0 while waiting, then `rf_wdata`=0xFFFFFF80. The same access with LBU gives 0x00000080.
- Write to x0: rd=0, rd_wen=1. Required: `rf_wen`=0 and `commit_valid`=1.
- Reset asserted while in WAIT_MEM, with `mem_rvalid` arriving afterwards. Required: no `rf_wen`, no `commit_valid`, and `in_ready`=1 right after reset.
- With `WB_BYPASS_EN` defined: ALU rd=7, data 0xA5. Required: `byp_valid`=1, `byp_addr`=7, `byp_data`=0xA5 in the write cycle. Without the macro, `byp_valid` stays 0.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: holds one completed instruction, extends load data by lane and drives the
// register file write port plus a commit pulse. Define WB_BYPASS_EN to expose the write as a bypass entry.
module wb_stage #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_rd_wen,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic                  in_is_load,
  input  logic [2:0]            in_load_fn,
  input  logic [1:0]            in_addr_lo,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  commit_valid,
  output logic [DATA_WIDTH-1:0] commit_pc,
  output logic                  byp_valid,
  output logic [ADDR_WIDTH-1:0] byp_addr,
  output logic [DATA_WIDTH-1:0] byp_data
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic                  rd_wen_q;
  logic [2:0]            load_fn_q;
  logic [1:0]            addr_lo_q;
  logic                  accept;
  logic [DATA_WIDTH-1:0] load_d;

  // Lane select with zero fill; misaligned halfwords simply see zeros in the upper lane.
  function automatic logic [DATA_WIDTH-1:0] load_ext(input logic [2:0]            fn,
                                                     input logic [1:0]            lo,
                                                     input logic [DATA_WIDTH-1:0] word);
    logic [DATA_WIDTH-1:0] s;
    s = word >> {lo, 3'b000};
    case (fn)
      3'b000:  load_ext = {{(DATA_WIDTH-8){s[7]}}, s[7:0]};
      3'b001:  load_ext = {{(DATA_WIDTH-16){s[15]}}, s[15:0]};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, s[7:0]};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, s[15:0]};
      default: load_ext = word;
    endcase
  endfunction

  assign in_ready = (state_q == IDLE) || (state_q == WRITE);
  assign accept   = in_valid && in_ready;
  assign load_d   = load_ext(load_fn_q, addr_lo_q, mem_rdata);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      data_q    <= '0;
      rd_q      <= '0;
      rd_wen_q  <= 1'b0;
      load_fn_q <= '0;
      addr_lo_q <= '0;
    end else if (accept) begin
      pc_q      <= in_pc;
      rd_q      <= in_rd;
      rd_wen_q  <= in_rd_wen;
      load_fn_q <= in_load_fn;
      addr_lo_q <= in_addr_lo;
      if (in_is_load) begin
        state_q <= WAIT_MEM;
      end else begin
        state_q <= WRITE;
        data_q  <= in_result;
      end
    end else if (state_q == WAIT_MEM) begin
      if (mem_rvalid) begin
        data_q  <= load_d;
        state_q <= WRITE;
      end
    end else if (state_q == WRITE) begin
      state_q <= IDLE;
    end
  end

  assign rf_wen       = (state_q == WRITE) && rd_wen_q && (rd_q != '0);
  assign rf_waddr     = rd_q;
  assign rf_wdata     = data_q;
  assign commit_valid = (state_q == WRITE);
  assign commit_pc    = pc_q;

`ifdef WB_BYPASS_EN
  // Register file reads are not write-through, so decode forwards the value written this cycle.
  assign byp_valid = (state_q == WRITE) && rf_wen;
  assign byp_addr  = rf_waddr;
  assign byp_data  = rf_wdata;
`else
  assign byp_valid = 1'b0;
  assign byp_addr  = '0;
  assign byp_data  = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed and randomized bench for wb_stage with a behavioural model of load extension and retire timing.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic [31:0] in_result;
  logic        in_is_load;
  logic [2:0]  in_load_fn;
  logic [1:0]  in_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        byp_valid;
  logic [4:0]  byp_addr;
  logic [31:0] byp_data;

  int n_checks = 0;
  int n_fail   = 0;

  wb_stage #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_rd(in_rd),
    .in_rd_wen(in_rd_wen), .in_result(in_result), .in_is_load(in_is_load),
    .in_load_fn(in_load_fn), .in_addr_lo(in_addr_lo),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference load extension written as plain lane arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] fn, input logic [1:0] lo,
                                           input logic [31:0] word);
    longint s;
    longint v;
    s = longint'(word) / (longint'(1) << (8 * int'(lo)));
    case (fn)
      3'd0: begin v = s % 256;   if (v >= 128)   v = v - 256;   end
      3'd1: begin v = s % 65536; if (v >= 32768) v = v - 65536; end
      3'd4: v = s % 256;
      3'd5: v = s % 65536;
      default: v = longint'(word);
    endcase
    return v[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs();
    in_pc      = $urandom;
    in_rd      = 5'($urandom);
    in_rd_wen  = 1'($urandom);
    in_result  = $urandom;
    in_is_load = 1'($urandom);
    in_load_fn = 3'($urandom);
    in_addr_lo = 2'($urandom);
  endtask

  task automatic issue(input logic [4:0] rd, input logic wen, input logic [31:0] res,
                       input logic [31:0] pc, input logic ld, input logic [2:0] fn,
                       input logic [1:0] lo);
    in_valid = 1'b1; in_rd = rd; in_rd_wen = wen; in_result = res; in_pc = pc;
    in_is_load = ld; in_load_fn = fn; in_addr_lo = lo;
    chk("ready_at_issue", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    scramble_inputs();
  endtask

  task automatic expect_retire(input string tag, input logic [4:0] rd, input logic wen,
                               input logic [31:0] data, input logic [31:0] pc);
    logic exp_wen;
    exp_wen = wen && (rd != 5'd0);
    chk({tag, "_rf_wen"}, 32'(rf_wen), 32'(exp_wen));
    chk({tag, "_commit"}, 32'(commit_valid), 32'd1);
    chk({tag, "_pc"}, commit_pc, pc);
    if (exp_wen) begin
      chk({tag, "_waddr"}, 32'(rf_waddr), 32'(rd));
      chk({tag, "_wdata"}, rf_wdata, data);
    end
`ifdef WB_BYPASS_EN
    chk({tag, "_byp_valid"}, 32'(byp_valid), 32'(exp_wen));
    if (exp_wen) begin
      chk({tag, "_byp_addr"}, 32'(byp_addr), 32'(rd));
      chk({tag, "_byp_data"}, byp_data, data);
    end
`else
    chk({tag, "_byp_valid"}, 32'(byp_valid), 32'd0);
`endif
  endtask

  task automatic expect_quiet(input string tag);
    chk({tag, "_rf_wen"}, 32'(rf_wen), 32'd0);
    chk({tag, "_commit"}, 32'(commit_valid), 32'd0);
    chk({tag, "_byp_valid"}, 32'(byp_valid), 32'd0);
  endtask

  // Holds the stage in WAIT_MEM for dly cycles, offering garbage instructions that must be refused.
  task automatic mem_return(input string tag, input int dly, input logic [31:0] word);
    for (int i = 0; i < dly; i++) begin
      chk({tag, "_ready_wait"}, 32'(in_ready), 32'd0);
      expect_quiet({tag, "_wait"});
      in_valid   = 1'($urandom);
      mem_rvalid = (i == dly - 1);
      mem_rdata  = (i == dly - 1) ? word : $urandom;
      tick();
    end
    in_valid   = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
  endtask

  initial begin
    logic [4:0]  rd;
    logic        wen;
    logic        ld;
    logic [2:0]  fn;
    logic [1:0]  lo;
    logic [31:0] res;
    logic [31:0] pc;
    logic [31:0] word;
    logic [31:0] exp_data;

    rst = 1'b1; in_valid = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    scramble_inputs();
    tick();
    tick();
    chk("rst_ready", 32'(in_ready), 32'd1);
    expect_quiet("rst");
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_commit_pc", commit_pc, 32'd0);
    chk("rst_byp_addr", 32'(byp_addr), 32'd0);
    chk("rst_byp_data", byp_data, 32'd0);
    rst = 1'b0;
    tick();

    issue(5'd5, 1'b1, 32'h1234, 32'h100, 1'b0, 3'd0, 2'd0);
    expect_retire("alu", 5'd5, 1'b1, 32'h1234, 32'h100);
    tick();
    expect_quiet("alu_after");

    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_rd = 5'(i); in_rd_wen = 1'b1; in_result = 32'(i * 16'h1111);
      in_pc = 32'(32'h200 + 4 * i); in_is_load = 1'b0; in_load_fn = 3'd0; in_addr_lo = 2'd0;
      chk("b2b_ready", 32'(in_ready), 32'd1);
      tick();
      expect_retire("b2b", 5'(i), 1'b1, 32'(i * 16'h1111), 32'(32'h200 + 4 * i));
    end
    in_valid = 1'b0;
    tick();
    expect_quiet("b2b_after");

    issue(5'd9, 1'b1, $urandom, 32'h300, 1'b1, 3'b000, 2'd2);
    mem_return("lb", 3, 32'h0080FF00);
    expect_retire("lb", 5'd9, 1'b1, 32'hFFFFFF80, 32'h300);
    issue(5'd10, 1'b1, $urandom, 32'h304, 1'b1, 3'b100, 2'd2);
    mem_return("lbu", 3, 32'h0080FF00);
    expect_retire("lbu", 5'd10, 1'b1, 32'h00000080, 32'h304);
    tick();

    issue(5'd0, 1'b1, 32'hDEAD, 32'h400, 1'b0, 3'd0, 2'd0);
    expect_retire("x0", 5'd0, 1'b1, 32'hDEAD, 32'h400);
    tick();

    issue(5'd7, 1'b1, 32'hA5, 32'h500, 1'b0, 3'd0, 2'd0);
    expect_retire("byp", 5'd7, 1'b1, 32'hA5, 32'h500);
    tick();

    mem_rvalid = 1'b1; mem_rdata = $urandom;
    tick();
    mem_rvalid = 1'b0;
    expect_quiet("stray_rvalid");

    issue(5'd12, 1'b1, $urandom, 32'h600, 1'b1, 3'b010, 2'd0);
    chk("rstmid_ready_wait", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("rstmid_ready", 32'(in_ready), 32'd1);
    expect_quiet("rstmid");
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = $urandom;
    tick();
    mem_rvalid = 1'b0;
    expect_quiet("rstmid_after");
    chk("rstmid_ready_after", 32'(in_ready), 32'd1);
    tick();
    expect_quiet("rstmid_after2");

    for (int t = 0; t < 60; t++) begin
      rd   = 5'($urandom);
      wen  = 1'($urandom);
      ld   = 1'($urandom);
      fn   = 3'($urandom);
      lo   = 2'($urandom);
      res  = $urandom;
      pc   = $urandom;
      word = $urandom;
      if (ld && ($urandom % 4 == 0)) word = {word[31:24] | 8'h80, word[23:16] | 8'h80,
                                             word[15:8] | 8'h80, word[7:0] | 8'h80};
      exp_data = ld ? ref_load(fn, lo, word) : res;
      issue(rd, wen, res, pc, ld, fn, lo);
      if (ld) mem_return("rnd_ld", 1 + int'($urandom % 4), word);
      expect_retire(ld ? "rnd_ld" : "rnd_alu", rd, wen, exp_data, pc);
      for (int g = 0; g < int'($urandom % 3); g++) begin
        mem_rvalid = 1'($urandom);
        tick();
        mem_rvalid = 1'b0;
        expect_quiet("rnd_gap");
        chk("rnd_gap_ready", 32'(in_ready), 32'd1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
